// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle between IF/ID (producer) and decode/execute (consumer)
// for the immediate generator.
interface imm_gen_pipe_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic [XLEN-1:0] out_target;
    logic [XLEN-1:0] out_pc;
    logic            out_illegal;

    modport slave (
        input  flush, in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_target, out_pc, out_illegal
    );

    modport master (
        output flush, in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_target, out_pc, out_illegal
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Opcode-driven immediate generator with pc+imm target, buffered by a
// 2-entry skid stage so in_ready never depends combinationally on out_ready.
module imm_gen_pipe #(
    parameter int XLEN   = 32,
    parameter int RV64_W = 1
) (
    input logic            clk,
    input logic            rst,
    imm_gen_pipe_if.slave  bus
);
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    localparam bit W_EN = (XLEN == 64) && (RV64_W != 0);

    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_IMM     = 7'b0010011;
    localparam logic [6:0] OP_IMM_32  = 7'b0011011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_OP      = 7'b0110011;
    localparam logic [6:0] OP_OP_32   = 7'b0111011;
    localparam logic [6:0] OP_SYSTEM  = 7'b1110011;
    localparam logic [6:0] OP_FENCE   = 7'b0001111;

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_SHIFT = 3'd2,
        FMT_S     = 3'd3,
        FMT_U     = 3'd4,
        FMT_B     = 3'd5,
        FMT_J     = 3'd6
    } fmt_e;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        logic [XLEN-1:0] pc;
        fmt_e            fmt;
        logic            illegal;
    } beat_t;

    logic [31:0] inst;
    logic [6:0]  opcode;
    logic        is_shift;
    logic        s;
    fmt_e        fmt;
    logic        illegal;
    logic [XLEN-1:0] imm;
    beat_t       in_beat;

    assign inst     = bus.in_inst;
    assign opcode   = inst[6:0];
    assign is_shift = (inst[14:12] == 3'b001) || (inst[14:12] == 3'b101);
    assign s        = inst[31];

    always_comb begin
        fmt     = FMT_NONE;
        illegal = 1'b0;
        unique case (opcode)
            OP_LOAD, OP_JALR:             fmt = FMT_I;
            OP_IMM:                       fmt = is_shift ? FMT_SHIFT : FMT_I;
            OP_IMM_32: begin
                if (W_EN) fmt = is_shift ? FMT_SHIFT : FMT_I;
                else      illegal = 1'b1;
            end
            OP_STORE:                     fmt = FMT_S;
            OP_LUI, OP_AUIPC:             fmt = FMT_U;
            OP_BRANCH:                    fmt = FMT_B;
            OP_JAL:                       fmt = FMT_J;
            OP_OP, OP_OP_32, OP_SYSTEM, OP_FENCE: fmt = FMT_NONE;
            default:                      illegal = 1'b1;
        endcase
    end

    // RV64 OP-IMM shifts carry a 6-bit shamt; every other shift uses 5 bits.
    always_comb begin
        imm = '0;
        unique case (fmt)
            FMT_I:     imm = {{(XLEN-12){s}}, inst[31:20]};
            FMT_SHIFT: begin
                if (XLEN == 64 && opcode == OP_IMM) imm = XLEN'(inst[25:20]);
                else                                imm = XLEN'(inst[24:20]);
            end
            FMT_S:     imm = {{(XLEN-12){s}}, inst[31:25], inst[11:7]};
            FMT_U:     imm = {{(XLEN-31){s}}, inst[30:12], 12'b0};
            FMT_B:     imm = {{(XLEN-12){s}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_J:     imm = {{(XLEN-20){s}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            default:   imm = '0;
        endcase
    end

    always_comb begin
        in_beat.imm     = imm;
        in_beat.target  = bus.in_pc + imm;
        in_beat.pc      = bus.in_pc;
        in_beat.fmt     = fmt;
        in_beat.illegal = illegal;
    end

    beat_t main_q, main_d, skid_q, skid_d;
    logic  main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
    logic  accept, drain;

    assign accept = bus.in_valid & ~skid_valid_q;
    assign drain  = main_valid_q & bus.out_ready;

    // Main refills from skid first so beats leave in arrival order; skid only
    // catches a beat when main is held by backpressure.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (bus.flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || drain) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d       = in_beat;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = in_beat;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign bus.in_ready    = ~skid_valid_q;
    assign bus.out_valid   = main_valid_q;
    assign bus.out_imm     = main_q.imm;
    assign bus.out_fmt     = main_q.fmt;
    assign bus.out_target  = main_q.target;
    assign bus.out_pc      = main_q.pc;
    assign bus.out_illegal = main_q.illegal;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances driven in
// lockstep, checking decode, targets, backpressure ordering, flush and reset.
module tb_imm_gen_pipe;
    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    imm_gen_pipe_if #(.XLEN(32)) b32 ();
    imm_gen_pipe_if #(.XLEN(64)) b64 ();

    imm_gen_pipe #(.XLEN(32), .RV64_W(1)) dut32 (.clk(clk), .rst(rst), .bus(b32.slave));
    imm_gen_pipe #(.XLEN(64), .RV64_W(1)) dut64 (.clk(clk), .rst(rst), .bus(b64.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] inst, input logic [63:0] pc);
        b32.in_valid = valid;
        b32.in_inst  = inst;
        b32.in_pc    = pc[31:0];
        b64.in_valid = valid;
        b64.in_inst  = inst;
        b64.in_pc    = pc;
    endtask

    task automatic setControl(input logic outReady, input logic flushIn);
        b32.out_ready = outReady;
        b32.flush     = flushIn;
        b64.out_ready = outReady;
        b64.flush     = flushIn;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Checks a valid beat on either instance; narrow outputs are zero-extended.
    task automatic checkBeat(input string tag, input bit wide, input logic [63:0] imm,
                             input logic [2:0] fmt, input logic [63:0] target,
                             input logic [63:0] pc, input logic illegal);
        if (wide) begin
            checkOutput({tag, ".valid"},   64'(b64.out_valid),   64'd1);
            checkOutput({tag, ".imm"},     b64.out_imm,          imm);
            checkOutput({tag, ".fmt"},     64'(b64.out_fmt),     64'(fmt));
            checkOutput({tag, ".target"},  b64.out_target,       target);
            checkOutput({tag, ".pc"},      b64.out_pc,           pc);
            checkOutput({tag, ".illegal"}, 64'(b64.out_illegal), 64'(illegal));
        end else begin
            checkOutput({tag, ".valid"},   64'(b32.out_valid),   64'd1);
            checkOutput({tag, ".imm"},     64'(b32.out_imm),     imm);
            checkOutput({tag, ".fmt"},     64'(b32.out_fmt),     64'(fmt));
            checkOutput({tag, ".target"},  64'(b32.out_target),  target);
            checkOutput({tag, ".pc"},      64'(b32.out_pc),      pc);
            checkOutput({tag, ".illegal"}, 64'(b32.out_illegal), 64'(illegal));
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        applyStimulus(1'b0, 32'h0, 64'h0);
        setControl(1'b1, 1'b0);
        tick;
        tick;

        checkOutput("reset.valid",   64'(b32.out_valid),   64'd0);
        checkOutput("reset.ready",   64'(b32.in_ready),    64'd1);
        checkOutput("reset.imm",     64'(b32.out_imm),     64'd0);
        checkOutput("reset.fmt",     64'(b32.out_fmt),     64'd0);
        checkOutput("reset.target",  64'(b32.out_target),  64'd0);
        checkOutput("reset.pc",      64'(b32.out_pc),      64'd0);
        checkOutput("reset.illegal", 64'(b32.out_illegal), 64'd0);
        checkOutput("reset.valid64", 64'(b64.out_valid),   64'd0);
        rst = 1'b0;
        tick;

        // Back-to-back single beats, one result per cycle.
        applyStimulus(1'b1, 32'hFFF00093, 64'h0);
        tick;
        checkBeat("addi_neg", 1'b0, 64'hFFFFFFFF, 3'd1, 64'hFFFFFFFF, 64'h0, 1'b0);
        checkBeat("addi_neg64", 1'b1, 64'hFFFFFFFFFFFFFFFF, 3'd1, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b0);

        applyStimulus(1'b1, 32'h4030D093, 64'h10);
        tick;
        checkBeat("srai", 1'b0, 64'h3, 3'd2, 64'h13, 64'h10, 1'b0);

        applyStimulus(1'b1, 32'h0020A423, 64'h20);
        tick;
        checkBeat("sw", 1'b0, 64'h8, 3'd3, 64'h28, 64'h20, 1'b0);

        applyStimulus(1'b1, 32'h123452B7, 64'h30);
        tick;
        checkBeat("lui", 1'b0, 64'h12345000, 3'd4, 64'h12345030, 64'h30, 1'b0);

        applyStimulus(1'b1, 32'hFE000EE3, 64'h100);
        tick;
        checkBeat("beq_back", 1'b0, 64'hFFFFFFFC, 3'd5, 64'hFC, 64'h100, 1'b0);

        applyStimulus(1'b1, 32'h0080006F, 64'h200);
        tick;
        checkBeat("jal", 1'b0, 64'h8, 3'd6, 64'h208, 64'h200, 1'b0);

        applyStimulus(1'b1, 32'h00000000, 64'h300);
        tick;
        checkBeat("illegal0", 1'b0, 64'h0, 3'd0, 64'h300, 64'h300, 1'b1);

        applyStimulus(1'b1, 32'h00B50533, 64'h304);
        tick;
        checkBeat("add_none", 1'b0, 64'h0, 3'd0, 64'h304, 64'h304, 1'b0);

        applyStimulus(1'b1, 32'h0010851B, 64'h308);
        tick;
        checkBeat("addiw32", 1'b0, 64'h0, 3'd0, 64'h308, 64'h308, 1'b1);
        checkBeat("addiw64", 1'b1, 64'h1, 3'd1, 64'h309, 64'h308, 1'b0);

        applyStimulus(1'b1, 32'h800002B7, 64'h1000);
        tick;
        checkBeat("lui_msb32", 1'b0, 64'h80000000, 3'd4, 64'h80001000, 64'h1000, 1'b0);
        checkBeat("lui_msb64", 1'b1, 64'hFFFFFFFF80000000, 3'd4, 64'hFFFFFFFF80001000, 64'h1000, 1'b0);

        applyStimulus(1'b1, 32'h03F09093, 64'h1004);
        tick;
        checkBeat("slli32", 1'b0, 64'h1F, 3'd2, 64'h1023, 64'h1004, 1'b0);
        checkBeat("slli64", 1'b1, 64'h3F, 3'd2, 64'h1043, 64'h1004, 1'b0);

        applyStimulus(1'b1, 32'h43F0D09B, 64'h1008);
        tick;
        checkBeat("sraiw32", 1'b0, 64'h0, 3'd0, 64'h1008, 64'h1008, 1'b1);
        checkBeat("sraiw64", 1'b1, 64'h1F, 3'd2, 64'h1027, 64'h1008, 1'b0);

        applyStimulus(1'b0, 32'h0, 64'h0);
        tick;
        checkOutput("idle.valid", 64'(b32.out_valid), 64'd0);

        // Backpressure: A to main, B to skid, C held until a slot frees up.
        setControl(1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00100093, 64'h400);
        tick;
        checkBeat("bp.A", 1'b0, 64'h1, 3'd1, 64'h401, 64'h400, 1'b0);
        checkOutput("bp.ready_after_A", 64'(b32.in_ready), 64'd1);
        applyStimulus(1'b1, 32'h00200093, 64'h404);
        tick;
        checkOutput("bp.ready_after_B", 64'(b32.in_ready), 64'd0);
        checkBeat("bp.A_stable1", 1'b0, 64'h1, 3'd1, 64'h401, 64'h400, 1'b0);
        applyStimulus(1'b1, 32'h00300093, 64'h408);
        tick;
        checkOutput("bp.ready_C_held", 64'(b32.in_ready), 64'd0);
        checkBeat("bp.A_stable2", 1'b0, 64'h1, 3'd1, 64'h401, 64'h400, 1'b0);
        tick;
        checkBeat("bp.A_stable3", 1'b0, 64'h1, 3'd1, 64'h401, 64'h400, 1'b0);
        setControl(1'b1, 1'b0);
        tick;
        checkBeat("bp.B", 1'b0, 64'h2, 3'd1, 64'h406, 64'h404, 1'b0);
        checkOutput("bp.ready_after_drain", 64'(b32.in_ready), 64'd1);
        tick;
        checkBeat("bp.C", 1'b0, 64'h3, 3'd1, 64'h40B, 64'h408, 1'b0);
        applyStimulus(1'b0, 32'h0, 64'h0);
        tick;
        checkOutput("bp.empty", 64'(b32.out_valid), 64'd0);

        // Flush with both entries full and a beat offered.
        setControl(1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00100093, 64'h500);
        tick;
        applyStimulus(1'b1, 32'h00200093, 64'h504);
        tick;
        checkOutput("flush.full_ready", 64'(b32.in_ready), 64'd0);
        setControl(1'b0, 1'b1);
        applyStimulus(1'b1, 32'h00500093, 64'h508);
        tick;
        checkOutput("flush.valid", 64'(b32.out_valid), 64'd0);
        checkOutput("flush.ready", 64'(b32.in_ready), 64'd1);
        setControl(1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 64'h0);
        tick;
        checkOutput("flush.no_ghost", 64'(b32.out_valid), 64'd0);

        // Flush beats accept even when in_ready=1.
        setControl(1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00100093, 64'h520);
        tick;
        setControl(1'b0, 1'b1);
        applyStimulus(1'b1, 32'h00600093, 64'h524);
        tick;
        checkOutput("flush2.valid", 64'(b32.out_valid), 64'd0);
        checkOutput("flush2.ready", 64'(b32.in_ready), 64'd1);
        setControl(1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 64'h0);
        tick;
        checkOutput("flush2.no_ghost", 64'(b32.out_valid), 64'd0);

        // Asynchronous reset between edges with the skid full.
        setControl(1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00100093, 64'h540);
        tick;
        applyStimulus(1'b1, 32'h00200093, 64'h544);
        tick;
        applyStimulus(1'b0, 32'h0, 64'h0);
        checkOutput("arst.pre_ready", 64'(b32.in_ready), 64'd0);
        rst = 1'b1;
        #2;
        checkOutput("arst.valid",  64'(b32.out_valid),  64'd0);
        checkOutput("arst.ready",  64'(b32.in_ready),   64'd1);
        checkOutput("arst.imm",    64'(b32.out_imm),    64'd0);
        checkOutput("arst.target", 64'(b32.out_target), 64'd0);
        checkOutput("arst.pc",     64'(b32.out_pc),     64'd0);
        rst = 1'b0;
        #1;
        setControl(1'b1, 1'b0);
        applyStimulus(1'b1, 32'h00700093, 64'h600);
        tick;
        checkBeat("arst.first", 1'b0, 64'h7, 3'd1, 64'h607, 64'h600, 1'b0);
        applyStimulus(1'b0, 32'h0, 64'h0);
        tick;
        checkOutput("arst.drained", 64'(b32.out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
